// File: rtl/tx_byte_scheduler.sv
// tx_byte_scheduler: packet-level round-robin scheduler for the PHY transmit byte path.
// Sends one granted byte per cycle, or the idle symbol 8'hBC, and inserts periodic skip windows.
//
// Ports:
//   clk_4f                byte clock
//   reset                 async active-low reset
//   enable                permits new grants (sampled in IDLE only)
//   req_valid/data/last   per-requester byte stream (data byte i in [8i+7:8i])
//   req_ready             combinational accept strobe, granted requester only
//   data_out/valid_out    registered byte to serializer (BC / 0 when idle)
//   grant_id              registered index of current/last grant
//   busy                  registered, high in SEND or SKP
module tx_byte_scheduler #(
  parameter int NREQ         = 2,
  parameter int SKP_INTERVAL = 16,
  parameter int SKP_LEN      = 2
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              enable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        data_out,
  output logic              valid_out,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SKP  = 2'd2
  } state_t;

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] CNT_MAX = 8'(SKP_INTERVAL);
  localparam logic [2:0] SKP_END = 3'(SKP_LEN - 1);

  state_t      r_state;
  logic [7:0]  r_data;
  logic        r_vld;
  logic [1:0]  r_grant;
  logic        r_busy;
  logic [1:0]  r_rr;
  logic [7:0]  r_cnt;
  logic [2:0]  r_skc;

  logic [NREQ-1:0] w_ready;
  logic [7:0]      w_byte;
  logic            w_last;
  logic            w_xfer;
  logic            w_any;
  logic [1:0]      w_sel;
  logic [2:0]      w_idx;
  logic [1:0]      w_rr_nxt;

  // Mux the granted requester's byte; ready only while sending.
  always_comb begin
    w_ready = '0;
    w_byte  = COM;
    w_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_state == S_SEND && r_grant == 2'(i)) begin
        w_ready[i] = 1'b1;
        w_byte     = req_data[8*i +: 8];
        w_last     = req_last[i];
      end
    end
  end

  assign w_xfer    = |(w_ready & req_valid);
  assign req_ready = w_ready;

  // Rotating priority: first valid requester at or after r_rr, mod NREQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr} + 3'(k);
      if (w_idx >= 3'(NREQ)) w_idx = w_idx - 3'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!w_any && w_idx == 3'(i) && req_valid[i]) begin
          w_any = 1'b1;
          w_sel = 2'(i);
        end
      end
    end
  end

  assign w_rr_nxt = (r_grant == 2'(NREQ - 1)) ? 2'd0 : r_grant + 2'd1;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_data  <= COM;
      r_vld   <= 1'b0;
      r_grant <= 2'd0;
      r_busy  <= 1'b0;
      r_rr    <= 2'd0;
      r_cnt   <= 8'd0;
      r_skc   <= 3'd0;
    end else begin
      r_data <= COM;
      r_vld  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // A due skip wins over both arbitration and enable.
          if (r_cnt >= CNT_MAX) begin
            r_state <= S_SKP;
            r_skc   <= 3'd0;
            r_busy  <= 1'b1;
          end else if (enable && w_any) begin
            r_state <= S_SEND;
            r_grant <= w_sel;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_data <= w_byte;
            r_vld  <= 1'b1;
            if (r_cnt < CNT_MAX) r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_rr    <= w_rr_nxt;
            end
          end
        end
        S_SKP: begin
          if (r_skc == SKP_END) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 8'd0;
          end else begin
            r_skc <= r_skc + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_vld;
  assign grant_id  = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// tb_tx_byte_scheduler: directed bench with byte scoreboard.
// Sources are per-requester queues; accepted bytes are pushed and checked on output.
module tb_tx_byte_scheduler;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  grant_id;
  logic        busy;

  logic [1:0]  hold;
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [9:0]  sbq[$];

  int          nchk = 0;
  int          nerr = 0;

  logic [1:0]  o_ready;
  logic        o_vld;
  logic [1:0]  o_gnt;
  logic        o_busy;
  logic [31:0] vsh;
  logic [15:0] gsh;
  logic        seen0;
  logic [1:0]  seenr;
  logic        seenv;

  tx_byte_scheduler #(
    .NREQ(2),
    .SKP_INTERVAL(8),
    .SKP_LEN(2)
  ) dut (
    .clk_4f(clk_4f),
    .reset(reset),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .data_out(data_out),
    .valid_out(valid_out),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (q0.size() != 0) begin
      req_valid[0]  = !hold[0];
      req_data[7:0] = q0[0][7:0];
      req_last[0]   = q0[0][8];
    end else begin
      req_valid[0]  = 1'b0;
      req_data[7:0] = 8'h00;
      req_last[0]   = 1'b0;
    end
    if (q1.size() != 0) begin
      req_valid[1]   = !hold[1];
      req_data[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end else begin
      req_valid[1]   = 1'b0;
      req_data[15:8] = 8'h00;
      req_last[1]    = 1'b0;
    end
  endtask

  // Sample mid-cycle, score outputs, record handshakes; advance sources after the edge.
  task automatic tick();
    logic [1:0] acc;
    logic [9:0] e;
    @(negedge clk_4f);
    o_ready = req_ready;
    o_vld   = valid_out;
    o_gnt   = grant_id;
    o_busy  = busy;
    vsh     = {vsh[30:0], valid_out};
    if (valid_out) begin
      gsh = {gsh[14:0], grant_id[0]};
      chk("sb_has_entry", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_data", data_out, e[7:0]);
        chk("sb_grant", grant_id, e[9:8]);
      end
    end else begin
      chk("idle_symbol", data_out, 8'hBC);
    end
    acc = req_valid & req_ready;
    if (acc[0]) sbq.push_back({2'd0, req_data[7:0]});
    if (acc[1]) sbq.push_back({2'd1, req_data[15:8]});
    @(posedge clk_4f);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic apply_reset();
    @(posedge clk_4f);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_data", data_out, 8'hBC);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    q0.delete();
    q1.delete();
    sbq.delete();
    hold = 2'b00;
    drive();
    @(posedge clk_4f);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 40 && (q0.size() != 0 || q1.size() != 0 ||
                      sbq.size() != 0 || busy)) begin
      tick();
      n++;
    end
    chk(tag, 32'(q0.size() + q1.size() + sbq.size()), 0);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    tick();
    while (o_ready == 2'b00 && n < 8) begin
      tick();
      n++;
    end
    chk(tag, o_ready, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    hold      = '0;
    vsh       = '0;
    gsh       = '0;
    apply_reset();

    // single requester, 3-byte packet
    enable = 1'b1;
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h22});
    q0.push_back({1'b1, 8'h33});
    drive();
    tick();
    chk("t1_idle_ready", o_ready, 2'b00);
    tick();
    chk("t1_grant_ready", o_ready, 2'b01);
    vsh = '0;
    repeat (3) tick();
    chk("t1_burst", vsh[2:0], 3'b111);
    tick();
    chk("t1_after_valid", o_vld, 0);
    chk("t1_grant_id", o_gnt, 0);
    chk("t1_busy", o_busy, 0);
    drain("t1_drain");

    // round robin with continuous 2-byte packets
    apply_reset();
    q0.push_back({1'b0, 8'hA0});
    q0.push_back({1'b1, 8'hA1});
    q0.push_back({1'b0, 8'hA2});
    q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b0, 8'hB0});
    q1.push_back({1'b1, 8'hB1});
    q1.push_back({1'b0, 8'hB2});
    q1.push_back({1'b1, 8'hB3});
    drive();
    vsh = '0;
    gsh = '0;
    repeat (14) tick();
    chk("t2_valid_pattern", vsh[13:0], 14'b00110110110110);
    chk("t2_grant_order", gsh[7:0], 8'b00110011);
    drain("t2_drain");

    // in-packet bubble on requester 1
    apply_reset();
    q1.push_back({1'b0, 8'hC0});
    q1.push_back({1'b0, 8'hC1});
    q1.push_back({1'b0, 8'hC2});
    q1.push_back({1'b1, 8'hC3});
    drive();
    tick();
    tick();
    chk("t3_grant1", o_ready, 2'b10);
    seen0 = o_ready[0];
    q0.push_back({1'b0, 8'hD0});
    q0.push_back({1'b1, 8'hD1});
    drive();
    tick();
    seen0 = seen0 | o_ready[0];
    hold[1] = 1'b1;
    drive();
    tick();
    seen0 = seen0 | o_ready[0];
    chk("t3_hold_ready_a", o_ready, 2'b10);
    tick();
    seen0 = seen0 | o_ready[0];
    chk("t3_hold_ready_b", o_ready, 2'b10);
    chk("t3_bubble_a", o_vld, 0);
    hold[1] = 1'b0;
    drive();
    tick();
    seen0 = seen0 | o_ready[0];
    chk("t3_bubble_b", o_vld, 0);
    tick();
    seen0 = seen0 | o_ready[0];
    chk("t3_no_grant0", seen0, 0);
    wait_grant("t3_next_grant0", 2'b01);
    drain("t3_drain");

    // skip insertion after a long packet
    apply_reset();
    for (int i = 0; i < 10; i++)
      q0.push_back({(i == 9), 8'(8'hE0 + i)});
    q1.push_back({1'b0, 8'hF0});
    q1.push_back({1'b1, 8'hF1});
    drive();
    vsh = '0;
    repeat (12) tick();
    chk("t4_uninterrupted", vsh[11:0], 12'b001111111111);
    chk("t4_idle_ready", o_ready, 2'b00);
    chk("t4_idle_busy", o_busy, 0);
    tick();
    chk("t4_skp1_ready", o_ready, 2'b00);
    chk("t4_skp1_busy", o_busy, 1);
    chk("t4_skp1_valid", o_vld, 0);
    tick();
    chk("t4_skp2_ready", o_ready, 2'b00);
    chk("t4_skp2_busy", o_busy, 1);
    chk("t4_skp2_valid", o_vld, 0);
    wait_grant("t4_next_grant1", 2'b10);
    drain("t4_drain");

    // enable gating
    enable = 1'b0;
    apply_reset();
    q0.push_back({1'b0, 8'h5A});
    q0.push_back({1'b1, 8'hA5});
    drive();
    seenr = 2'b00;
    seenv = 1'b0;
    repeat (4) begin
      tick();
      seenr = seenr | o_ready;
      seenv = seenv | o_vld;
    end
    chk("t5_gated_ready", seenr, 2'b00);
    chk("t5_gated_valid", seenv, 0);
    enable = 1'b1;
    tick();
    chk("t5_enable_idle", o_ready, 2'b00);
    tick();
    chk("t5_enable_grant", o_ready, 2'b01);
    drain("t5_drain");

    // asynchronous reset in the middle of a packet
    apply_reset();
    for (int i = 0; i < 5; i++)
      q0.push_back({(i == 4), 8'(8'h70 + i)});
    drive();
    repeat (3) tick();
    chk("t6_busy_pre", busy, 1);
    apply_reset();
    tick();
    chk("t6_post_ready", o_ready, 2'b00);
    chk("t6_post_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
